tri_bus_arbiter: RTL and testbench
==================================

# tri_bus_arbiter

Round-robin arbiter and sequencer for a shared `tri` net driven by N requesters. It grants one requester at a time and drives that requester's output enable. It enforces a one-cycle all-drivers-off turnaround between owners so the resolved net never sees two active drivers, and it bounds each ownership with a hold limit. It sits between the requester agents and their tristate drivers in the Verilog net-type test designs.

## Interface
Parameters:
- `N`, default 4: number of requesters. Legal values are N ≥ 2.
- `MAX_HOLD`, default 8: maximum consecutive GRANT cycles per ownership. Legal values are MAX_HOLD ≥ 1.

Ports:
- `clk`  in  1  the single clock. Everything is rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  N  per-requester request level. Must be held for as long as bus ownership is wanted.
- `gnt`  out  N  one-hot grant. All zero outside GRANT.
- `oe`  out  N  tristate driver enables. Always equal to `gnt`, registered, never combinational from `req`.
- `owner`  out  $clog2(N)  index of the current owner. Holds the last owner when not busy.
- `busy`  out  1  high exactly when in GRANT.
- `preempt`  out  1  one-cycle pulse when ownership is ended by the hold limit while the owner's `req` is still high.

## Operation
- State machine: IDLE, GRANT, TURN.
- Round-robin pointer `ptr` (width $clog2(N)) is the highest-priority index.
  - Selection takes the first set `req[k]`, scanning k = ptr, ptr+1, … cyclically modulo N.
- Hold counter `hcnt`, width $clog2(MAX_HOLD+1), counts the cycles spent in GRANT.
- Reset values (async on `rst_n`=0): state IDLE, `gnt`=0, `oe`=0, `owner`=0, `busy`=0, `preempt`=0, `ptr`=0, `hcnt`=0.
- IDLE:
  - If any `req` is set, select index k, load `gnt`=`oe`=1<<k, `owner`=k, `hcnt`=1, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, current owner i:
  - If `req[i]`=0: release.
  - Else if `hcnt`==MAX_HOLD: release and pulse `preempt`.
  - Else `hcnt`++.
  - Release means: next cycle `gnt`=`oe`=0, `busy`=0, `ptr`=(i+1) mod N (wrap from N-1 to 0), state TURN.
- TURN:
  - Exactly one cycle with all enables low.
  - Arbitration is evaluated during TURN with the updated `ptr`. If any `req` is set, go directly to GRANT with the same load as IDLE. Otherwise go to IDLE.
- Requests from non-owners during GRANT are ignored; they are sampled only in IDLE or TURN.
- If the owner's `req` drops and re-rises within a GRANT, the drop still releases ownership. No re-grant happens without a TURN.
- A requester re-requesting immediately after release has the lowest priority, because `ptr` has moved past it.
- With MAX_HOLD=1, every grant lasts one cycle, and `preempt` pulses whenever `req` is still high.
- Reset asserted mid-GRANT: all enables drop asynchronously, in the same instant as `rst_n` falls.
- X on `req` is not filtered; requester behaviour is undefined until `req` is known.

## Timing
- `req` rising in IDLE at edge t → `gnt`/`oe` high after edge t+1 (1-cycle latency).
- Ownership length: 1..MAX_HOLD cycles of `busy`=1.
- `req[i]` falling, sampled at edge t → `gnt[i]` low after edge t.
  - The owner may still be granted during the cycle it drops `req`.
- Handoff: the last GRANT cycle of owner A, then one TURN cycle (all `oe` zero), then the first GRANT cycle of owner B. The minimum gap is exactly 1 cycle.
- `preempt` is high during the TURN cycle that follows a hold-limit release, and only then.
- `owner` changes only on entry to GRANT.
- Invariant checked every cycle: $countones(`oe`) ≤ 1, and `oe`==`gnt`.

## Test plan
- Reset: N=4, MAX_HOLD=8. Assert `rst_n`=0 while GRANT with `gnt`=4'b0010 → `gnt`=`oe`=0, `busy`=0 immediately. After release with `req`=0 → IDLE, `ptr`=0.
- Single request: `req`=4'b0100 for 3 cycles from IDLE → `gnt`=4'b0100 for 3 cycles starting 1 cycle after `req`, `owner`=2, then TURN, then IDLE, `ptr`=3.
- Rotation with wrap: `req`=4'b1111 held, MAX_HOLD=2 → owners 0,1,2,3,0, each for 2 cycles, each followed by one all-zero TURN cycle with `preempt`=1.
- Back-to-back handoff: owner 3 releases with `req`=4'b1001 → `ptr` wraps to 0, TURN, then `gnt`=4'b0001. Requester 3 re-requesting is served only after requester 0.
- Hold limit exact: MAX_HOLD=8, `req[1]` held 20 cycles alone → GRANT 8 cycles, `preempt` pulse, TURN, GRANT 8 cycles, `preempt` pulse, TURN, GRANT 2 more cycles (`req[1]` drops) → IDLE. `oe` is never set during a TURN cycle.
- Non-owner ignored: while owner 0 is in GRANT, pulse `req[2]` for 1 cycle → no change to `gnt`. At the next TURN, grant follows current `req` only.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tri_bus_arbiter: round-robin owner sequencer for a shared tristate net.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 preempt
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    gnt_q;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   ptr_q;
  logic [HW-1:0]   hcnt_q;
  logic            busy_q;
  logic            preempt_q;

  logic            sel_any;
  logic [PW-1:0]   sel_idx;
  logic [PW:0]     cand;
  logic [PW-1:0]   ptr_next;
  logic            owner_req;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      cand = {1'b0, ptr_q} + (PW + 1)'(j);
      if (cand >= (PW + 1)'(N)) begin
        cand = cand - (PW + 1)'(N);
      end
      if (req[cand[PW-1:0]]) begin
        sel_any = 1'b1;
        sel_idx = cand[PW-1:0];
      end
    end
  end

  assign ptr_next  = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
  assign owner_req = req[owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      case (state_q)
        S_GRANT: begin
          if (!owner_req || hcnt_q == HW'(MAX_HOLD)) begin
            // A release with req still high can only be the hold limit.
            state_q   <= S_TURN;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            hcnt_q    <= '0;
            ptr_q     <= ptr_next;
            preempt_q <= owner_req;
          end else begin
            hcnt_q    <= hcnt_q + HW'(1);
            preempt_q <= 1'b0;
          end
        end
        S_IDLE, S_TURN: begin
          preempt_q <= 1'b0;
          if (sel_any) begin
            state_q <= S_GRANT;
            gnt_q   <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
            owner_q <= sel_idx;
            hcnt_q  <= HW'(1);
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          gnt_q     <= '0;
          busy_q    <= 1'b0;
          preempt_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign oe      = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tri_bus_arbiter: directed checks of tri_bus_arbiter (MAX_HOLD 8 and 2).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tri_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req8, req2;
  logic [3:0] gnt8, oe8, gnt2, oe2;
  logic [1:0] owner8, owner2;
  logic       busy8, busy2, pre8, pre2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tri_bus_arbiter #(.N(4), .MAX_HOLD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .oe(oe8),
    .owner(owner8), .busy(busy8), .preempt(pre8)
  );

  tri_bus_arbiter #(.N(4), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .gnt(gnt2), .oe(oe2),
    .owner(owner2), .busy(busy2), .preempt(pre2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp8(input string tag, input logic [3:0] g, input logic [1:0] o,
                      input logic b, input logic p);
    chk({tag, ".gnt"},     32'(gnt8),   32'(g));
    chk({tag, ".oe"},      32'(oe8),    32'(g));
    chk({tag, ".owner"},   32'(owner8), 32'(o));
    chk({tag, ".busy"},    32'(busy8),  32'(b));
    chk({tag, ".preempt"}, 32'(pre8),   32'(p));
  endtask

  task automatic exp2(input string tag, input logic [3:0] g, input logic [1:0] o,
                      input logic b, input logic p);
    chk({tag, ".gnt"},     32'(gnt2),   32'(g));
    chk({tag, ".oe"},      32'(oe2),    32'(g));
    chk({tag, ".owner"},   32'(owner2), 32'(o));
    chk({tag, ".busy"},    32'(busy2),  32'(b));
    chk({tag, ".preempt"}, 32'(pre2),   32'(p));
  endtask

  // Advance one clock and check the one-driver invariant on both instances.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv8.onehot", 32'($countones(oe8) <= 1), 32'd1);
    chk("inv2.onehot", 32'($countones(oe2) <= 1), 32'd1);
    chk("inv8.oe_eq_gnt", 32'(oe8), 32'(gnt8));
    chk("inv2.oe_eq_gnt", 32'(oe2), 32'(gnt2));
  endtask

  initial begin
    rst_n = 1'b0;
    req8  = 4'b0000;
    req2  = 4'b0000;

    // Reset state, then async reset during a grant to requester 1
    tick();
    exp8("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    exp2("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req8  = 4'b0010;
    tick();
    exp8("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp8("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    req8 = 4'b0000;
    #1 rst_n = 1'b1;
    tick();
    exp8("post_rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req8 = 4'b1111;
    tick();
    exp8("ptr0_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req8 = 4'b0000;
    tick();
    exp8("ptr0_turn", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    exp8("ptr0_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request held three cycles
    req8 = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp8("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req8 = 4'b0000;
    tick();
    exp8("single_turn", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    exp8("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    req8 = 4'b1001;
    tick();
    exp8("ptr3_grant", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Back-to-back handoff with pointer wrap
    req8 = 4'b0001;
    tick();
    exp8("wrap_turn", 4'b0000, 2'd3, 1'b0, 1'b0);
    req8 = 4'b1001;
    tick();
    exp8("wrap_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req8 = 4'b1000;
    tick();
    exp8("wrap_turn2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    exp8("wrap_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req8 = 4'b0000;
    tick();
    exp8("wrap_turn3", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    exp8("wrap_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Hold limit: req[1] held 20 cycles with MAX_HOLD=8
    req8 = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 9 || c == 18)
        exp8("hold_preempt", 4'b0000, 2'd1, 1'b0, 1'b1);
      else
        exp8("hold_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req8 = 4'b0000;
    tick();
    exp8("hold_turn", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    exp8("hold_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Non-owner request pulse during grant is ignored
    req8 = 4'b0001;
    tick();
    exp8("nonown_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req8 = 4'b0101;
    tick();
    exp8("nonown_pulse", 4'b0001, 2'd0, 1'b1, 1'b0);
    req8 = 4'b0001;
    tick();
    exp8("nonown_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    req8 = 4'b0000;
    tick();
    exp8("nonown_turn", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    exp8("nonown_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Rotation with wrap, MAX_HOLD=2, all requesting
    req2 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp2("rot_g1", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
      tick();
      exp2("rot_g2", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
      tick();
      exp2("rot_turn", 4'b0000, 2'(k % 4), 1'b0, 1'b1);
    end
    req2 = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
